// File: rtl/cam_lookup_table_mp_pkg.sv
// Shared types and width helpers for the multi-port CAM lookup table.
package cam_lookup_table_mp_pkg;

  // Arbitration priority between the update channel and the lookup ports.
  typedef enum logic {
    TogUpd = 1'b0,
    TogLkp = 1'b1
  } toggle_e;

  // Index width that stays >= 1 even for a single-element range.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_lookup_table_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, pointer moves past the winner when enabled.
module cam_lookup_table_mp_rr_arbiter
  import cam_lookup_table_mp_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = ptr_width(N);
  localparam logic [PW:0] NUM = (PW + 1)'(N);

  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic [PW:0]   cand, nxt;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (PW + 1)'(i);
      if (cand >= NUM) cand = cand - NUM;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        gidx  = cand[PW-1:0];
      end
    end
    if (en && found) grant[gidx] = 1'b1;
    nxt = {1'b0, gidx} + (PW + 1)'(1);
    if (nxt >= NUM) nxt = '0;
    ptr_d = (en && found) ? nxt[PW-1:0] : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cam_lookup_table_mp.sv
// N-port associative key->value table with one joined update channel and FIFO eviction.
module cam_lookup_table_mp
  import cam_lookup_table_mp_pkg::*;
#(
  parameter int unsigned           TABLE_SIZE   = 64,
  parameter int unsigned           KEY_SIZE     = 32,
  parameter int unsigned           VALUE_SIZE   = 64,
  parameter int unsigned           LOOKUP_PORTS = 2,
  parameter logic [VALUE_SIZE-1:0] MISS_VALUE   = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LOOKUP_PORTS*KEY_SIZE-1:0]     s_lookup_req_index,
  input  logic [LOOKUP_PORTS-1:0]              s_lookup_req_valid,
  output logic [LOOKUP_PORTS-1:0]              s_lookup_req_ready,
  output logic [LOOKUP_PORTS*VALUE_SIZE-1:0]   s_lookup_value_data,
  output logic [LOOKUP_PORTS-1:0]              s_lookup_value_hit,
  output logic [LOOKUP_PORTS-1:0]              s_lookup_value_valid,
  input  logic [LOOKUP_PORTS-1:0]              s_lookup_value_ready,
  input  logic [KEY_SIZE-1:0]                  s_update_req_index,
  input  logic                                 s_update_req_index_valid,
  output logic                                 s_update_req_index_ready,
  input  logic [VALUE_SIZE-1:0]                s_update_req_data,
  input  logic                                 s_update_req_data_valid,
  output logic                                 s_update_req_data_ready
);

  localparam int unsigned N     = LOOKUP_PORTS;
  localparam int unsigned IDX_W = ptr_width(TABLE_SIZE);

  logic [TABLE_SIZE-1:0] ent_valid_q;
  logic [KEY_SIZE-1:0]   ent_key_q [TABLE_SIZE];
  logic [VALUE_SIZE-1:0] ent_val_q [TABLE_SIZE];
  logic [IDX_W-1:0]      wr_ptr_q;
  toggle_e               toggle_q;

  logic [N-1:0]          res_valid_q, res_hit_q;
  logic [VALUE_SIZE-1:0] res_data_q [N];

  logic [KEY_SIZE-1:0]   req_key [N];
  logic [N-1:0]          req_valid, val_ready, eligible, grant;
  logic                  upd_pend, any_elig, upd_win, lkp_en;
  logic [KEY_SIZE-1:0]   lkp_key;
  logic [VALUE_SIZE-1:0] lkp_val;
  logic                  lkp_hit, upd_hit;
  logic [IDX_W-1:0]      upd_idx;

  // External buses put port 0 in the most significant slice.
  for (genvar p = 0; p < N; p++) begin : g_port
    assign req_key[p]   = s_lookup_req_index[(N-1-p)*KEY_SIZE +: KEY_SIZE];
    assign req_valid[p] = s_lookup_req_valid[N-1-p];
    assign val_ready[p] = s_lookup_value_ready[N-1-p];
    assign s_lookup_req_ready[N-1-p]   = grant[p];
    assign s_lookup_value_valid[N-1-p] = res_valid_q[p];
    assign s_lookup_value_hit[N-1-p]   = res_hit_q[p];
    assign s_lookup_value_data[(N-1-p)*VALUE_SIZE +: VALUE_SIZE] = res_data_q[p];
  end

  assign upd_pend = s_update_req_index_valid & s_update_req_data_valid & ~rst;
  assign eligible = req_valid & (~res_valid_q | val_ready) & {N{~rst}};
  assign any_elig = |eligible;
  assign upd_win  = upd_pend & (~any_elig | (toggle_q == TogUpd));
  assign lkp_en   = any_elig & ~upd_win;

  assign s_update_req_index_ready = upd_win;
  assign s_update_req_data_ready  = upd_win;

  cam_lookup_table_mp_rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (eligible),
    .en    (lkp_en),
    .grant (grant)
  );

  // Parallel compare for both the granted lookup key and the update key.
  always_comb begin
    lkp_key = '0;
    for (int p = 0; p < N; p++) begin
      if (grant[p]) lkp_key = req_key[p];
    end
    lkp_hit = 1'b0;
    lkp_val = '0;
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int e = 0; e < TABLE_SIZE; e++) begin
      if (ent_valid_q[e] && ent_key_q[e] == lkp_key) begin
        lkp_hit = 1'b1;
        lkp_val = ent_val_q[e];
      end
      if (ent_valid_q[e] && ent_key_q[e] == s_update_req_index) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(e);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid_q <= '0;
      wr_ptr_q    <= '0;
      toggle_q    <= TogUpd;
      res_valid_q <= '0;
    end else begin
      if (upd_pend && any_elig) toggle_q <= (toggle_q == TogUpd) ? TogLkp : TogUpd;
      if (upd_win) begin
        if (upd_hit) begin
          ent_val_q[upd_idx] <= s_update_req_data;
        end else begin
          // wr_ptr walks slots in insert order, so a full table evicts the oldest insert.
          ent_key_q[wr_ptr_q]   <= s_update_req_index;
          ent_val_q[wr_ptr_q]   <= s_update_req_data;
          ent_valid_q[wr_ptr_q] <= 1'b1;
          wr_ptr_q              <= wr_ptr_q + IDX_W'(1);
        end
      end
      for (int p = 0; p < N; p++) begin
        if (grant[p]) begin
          res_valid_q[p] <= 1'b1;
          res_hit_q[p]   <= lkp_hit;
          res_data_q[p]  <= lkp_hit ? lkp_val : MISS_VALUE;
        end else if (val_ready[p]) begin
          res_valid_q[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_lookup_table_mp.sv
// Directed scoreboard bench for cam_lookup_table_mp with two lookup ports.
module tb_cam_lookup_table_mp;

  localparam int unsigned TS = 64;
  localparam int unsigned KW = 32;
  localparam int unsigned VW = 64;
  localparam int unsigned NP = 2;

  typedef struct packed {
    logic          hit;
    logic [VW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*KW-1:0]  lk_index;
  logic [NP-1:0]     lk_valid, lk_ready;
  logic [NP*VW-1:0]  val_data;
  logic [NP-1:0]     val_hit, val_valid, val_ready;
  logic [KW-1:0]     upd_index;
  logic              upd_idx_valid, upd_idx_ready;
  logic [VW-1:0]     upd_data;
  logic              upd_data_valid, upd_data_ready;

  always #5 clk = ~clk;

  cam_lookup_table_mp #(
    .TABLE_SIZE   (TS),
    .KEY_SIZE     (KW),
    .VALUE_SIZE   (VW),
    .LOOKUP_PORTS (NP),
    .MISS_VALUE   ('0)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_lookup_req_index       (lk_index),
    .s_lookup_req_valid       (lk_valid),
    .s_lookup_req_ready       (lk_ready),
    .s_lookup_value_data      (val_data),
    .s_lookup_value_hit       (val_hit),
    .s_lookup_value_valid     (val_valid),
    .s_lookup_value_ready     (val_ready),
    .s_update_req_index       (upd_index),
    .s_update_req_index_valid (upd_idx_valid),
    .s_update_req_index_ready (upd_idx_ready),
    .s_update_req_data        (upd_data),
    .s_update_req_data_valid  (upd_data_valid),
    .s_update_req_data_ready  (upd_data_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [KW-1:0] mkey [TS];
  logic [VW-1:0] mval [TS];
  logic          mvld [TS];
  int            mwp;

  logic [NP-1:0] acc, rgot, rhit;
  logic [VW-1:0] rdata [NP];
  logic          upd_acc;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < TS; e++) mvld[e] = 1'b0;
    mwp = 0;
  endtask

  function automatic exp_t model_lookup(input logic [KW-1:0] k);
    exp_t r;
    r.hit  = 1'b0;
    r.data = '0;
    for (int e = 0; e < TS; e++) begin
      if (mvld[e] && mkey[e] == k) begin
        r.hit  = 1'b1;
        r.data = mval[e];
      end
    end
    return r;
  endfunction

  task automatic model_update(input logic [KW-1:0] k, input logic [VW-1:0] v);
    logic found;
    found = 1'b0;
    for (int e = 0; e < TS; e++) begin
      if (mvld[e] && mkey[e] == k) begin
        mval[e] = v;
        found   = 1'b1;
      end
    end
    if (!found) begin
      mkey[mwp] = k;
      mval[mwp] = v;
      mvld[mwp] = 1'b1;
      mwp = (mwp + 1) % TS;
    end
  endtask

  function automatic int sb_size(input int p);
    return (p == 0) ? sb0.size() : sb1.size();
  endfunction

  // Sample just after the falling edge, then wait for the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    acc = '0;
    rgot = '0;
    upd_acc = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (val_valid[NP-1-p]) begin
        chk($sformatf("p%0d_result_expected", p), 64'(sb_size(p) != 0), 64'd1);
        if (sb_size(p) != 0) begin
          e = (p == 0) ? sb0[0] : sb1[0];
          chk($sformatf("p%0d_hit", p), 64'(val_hit[NP-1-p]), 64'(e.hit));
          chk($sformatf("p%0d_data", p), val_data[(NP-1-p)*VW +: VW], e.data);
          if (val_ready[NP-1-p]) begin
            if (p == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
            rgot[p]  = 1'b1;
            rhit[p]  = val_hit[NP-1-p];
            rdata[p] = val_data[(NP-1-p)*VW +: VW];
          end
        end
      end
      if (lk_valid[NP-1-p] && lk_ready[NP-1-p]) begin
        acc[p] = 1'b1;
        e = model_lookup(lk_index[(NP-1-p)*KW +: KW]);
        if (p == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    if (upd_idx_ready || upd_data_ready) begin
      chk("upd_ready_joined", 64'(upd_idx_ready), 64'(upd_data_ready));
      if (upd_idx_valid && upd_data_valid) begin
        upd_acc = 1'b1;
        model_update(upd_index, upd_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic v, input logic [KW-1:0] key);
    lk_index[(NP-1-p)*KW +: KW] = key;
    lk_valid[NP-1-p] = v;
  endtask

  task automatic do_lookup(input int p, input logic [KW-1:0] key, input logic exp_hit,
                           input logic [VW-1:0] exp_data, input string tag);
    int n;
    int lat;
    set_req(p, 1'b1, key);
    val_ready[NP-1-p] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc[p] && n < 20);
    set_req(p, 1'b0, key);
    chk({tag, "_accept"}, 64'(acc[p]), 64'd1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rgot[p] && lat < 20);
    chk({tag, "_latency"}, 64'(lat), 64'd1);
    chk({tag, "_hit"}, 64'(rhit[p]), 64'(exp_hit));
    chk({tag, "_data"}, rdata[p], exp_data);
  endtask

  task automatic do_update(input logic [KW-1:0] key, input logic [VW-1:0] val);
    int n;
    upd_index = key;
    upd_data = val;
    upd_idx_valid = 1'b1;
    upd_data_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!upd_acc && n < 20);
    upd_idx_valid = 1'b0;
    upd_data_valid = 1'b0;
    chk("update_accept", 64'(upd_acc), 64'd1);
  endtask

  task automatic drain();
    lk_valid = '0;
    upd_idx_valid = 1'b0;
    upd_data_valid = 1'b0;
    val_ready = '1;
    repeat (3) tick();
    chk("drain_p0_empty", 64'(sb0.size()), 64'd0);
    chk("drain_p1_empty", 64'(sb1.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    lk_index = '0;
    lk_valid = '1;
    val_ready = '1;
    upd_index = 32'h11;
    upd_data = 64'h55;
    upd_idx_valid = 1'b1;
    upd_data_valid = 1'b1;

    // 1: readys stay low under reset even with every valid raised.
    repeat (2) begin
      tick();
      chk("rst_lk_ready", 64'(lk_ready), 64'd0);
      chk("rst_upd_ready", 64'({upd_idx_ready, upd_data_ready}), 64'd0);
    end
    rst = 1'b0;
    lk_valid = '0;
    upd_idx_valid = 1'b0;
    upd_data_valid = 1'b0;
    tick();
    chk("rst_value_valid", 64'(val_valid), 64'd0);
    do_lookup(0, 32'h11, 1'b0, 64'h0, "t1_miss");

    // 2: contended update wins first, lookup in the following cycle sees it.
    upd_index = 32'h11;
    upd_data = 64'hAA;
    upd_idx_valid = 1'b1;
    upd_data_valid = 1'b1;
    set_req(1, 1'b1, 32'h11);
    tick();
    chk("t2_upd_first", 64'(upd_acc), 64'd1);
    chk("t2_lkp_blocked", 64'(acc[1]), 64'd0);
    upd_idx_valid = 1'b0;
    upd_data_valid = 1'b0;
    tick();
    chk("t2_lkp_granted", 64'(acc[1]), 64'd1);
    set_req(1, 1'b0, 32'h11);
    tick();
    chk("t2_got", 64'(rgot[1]), 64'd1);
    chk("t2_hit", 64'(rhit[1]), 64'd1);
    chk("t2_data", rdata[1], 64'hAA);
    do_update(32'h11, 64'hBB);
    do_lookup(1, 32'h11, 1'b1, 64'hBB, "t2_overwrite");

    // 3: fill, then two inserts evict the two oldest slots (0x11, then key 0).
    for (int k = 0; k < TS; k++) do_update(KW'(k), 64'h1000 + VW'(k));
    do_update(32'd100, 64'h1100);
    do_lookup(0, 32'h11, 1'b0, 64'h0, "t3_evict_11");
    do_lookup(0, 32'd0, 1'b1, 64'h1000, "t3_key0");
    do_lookup(0, 32'd100, 1'b1, 64'h1100, "t3_key100");
    do_update(32'd101, 64'h1101);
    do_lookup(0, 32'd0, 1'b0, 64'h0, "t3_evict_0");
    do_lookup(0, 32'd1, 1'b1, 64'h1001, "t3_key1");
    do_lookup(0, 32'd101, 1'b1, 64'h1101, "t3_key101");

    // 4: both ports streaming; last grant was p0 so p1 leads.
    set_req(0, 1'b1, 32'd1);
    set_req(1, 1'b1, 32'd101);
    val_ready = '1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t4_p0_grant_%0d", i), 64'(acc[0]), 64'(i % 2 == 1));
      chk($sformatf("t4_p1_grant_%0d", i), 64'(acc[1]), 64'(i % 2 == 0));
    end
    drain();

    // 5: update vs p0 every cycle; toggle currently favours lookup.
    set_req(0, 1'b1, 32'd5);
    upd_idx_valid = 1'b1;
    upd_data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      upd_index = 32'd200 + KW'(i);
      upd_data = 64'h2000 + VW'(i);
      tick();
      chk($sformatf("t5_lkp_%0d", i), 64'(acc[0]), 64'(i % 2 == 0));
      chk($sformatf("t5_upd_%0d", i), 64'(upd_acc), 64'(i % 2 == 1));
    end
    drain();
    upd_idx_valid = 1'b1;
    repeat (2) begin
      tick();
      chk("t5_idx_only", 64'({upd_idx_ready, upd_data_ready}), 64'd0);
    end
    upd_idx_valid = 1'b0;
    upd_data_valid = 1'b1;
    repeat (2) begin
      tick();
      chk("t5_data_only", 64'({upd_idx_ready, upd_data_ready}), 64'd0);
    end
    upd_data_valid = 1'b0;

    // 6: p1 backpressured; its held result is checked each cycle against the scoreboard.
    set_req(0, 1'b1, 32'd10);
    set_req(1, 1'b1, 32'd20);
    val_ready = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        chk("t6_p1_first", 64'(acc[1]), 64'd1);
      end else begin
        chk($sformatf("t6_p1_stalled_%0d", i), 64'(lk_ready[0]), 64'd0);
        chk($sformatf("t6_p1_held_%0d", i), 64'(val_valid[0]), 64'd1);
        chk($sformatf("t6_p0_runs_%0d", i), 64'(acc[0]), 64'd1);
      end
    end
    val_ready = '1;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_lk_ready", 64'(lk_ready), 64'd0);
    tick();
    chk("t6_rst_value_valid", 64'(val_valid), 64'd0);
    sb0.delete();
    sb1.delete();
    model_reset();
    rst = 1'b0;
    lk_valid = '0;
    tick();
    chk("t6_post_rst_valid", 64'(val_valid), 64'd0);
    set_req(0, 1'b1, 32'd10);
    set_req(1, 1'b1, 32'd20);
    tick();
    chk("t6_rr_reset_p0", 64'(acc[0]), 64'd1);
    chk("t6_rr_reset_p1", 64'(acc[1]), 64'd0);
    drain();
    do_lookup(0, 32'h11, 1'b0, 64'h0, "t6_miss_11");
    do_lookup(1, 32'd10, 1'b0, 64'h0, "t6_miss_10");
    upd_index = 32'h33;
    upd_data = 64'h77;
    upd_idx_valid = 1'b1;
    upd_data_valid = 1'b1;
    set_req(0, 1'b1, 32'h33);
    tick();
    chk("t6_toggle_reset_upd", 64'(upd_acc), 64'd1);
    upd_idx_valid = 1'b0;
    upd_data_valid = 1'b0;
    tick();
    chk("t6_lkp_after_upd", 64'(acc[0]), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
